light_dance_engine: RTL and testbench
=====================================

# light_dance_engine

Parametrised LED pattern generator for the light-dance datapath. It replaces per-bit select muxing with a registered WIDTH-bit pattern register and a programmable prescaler. The pattern advances on prescaler ticks in one of four modes: rotate left, rotate right, ping-pong and fill/drain. It drives the LED bank directly and emits step and wrap strobes for higher-level choreography logic.

## Interface
- WIDTH, 8, number of LEDs / pattern bits (≥2)
- DIV_W, 16, prescaler counter/divisor width
- clk  input  1  system clock, all state changes on rising edge
- nrst  input  1  reset, asynchronous, active-low
- en  input  1  prescaler enable; low freezes counter and pattern
- mode  input  2  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill/drain
- load  input  1  synchronous load of seed (highest priority after reset)
- seed  input  WIDTH  pattern loaded on load
- div  input  DIV_W  tick period minus one (0 = tick every en cycle)
- leds  output  WIDTH  registered pattern
- step  output  1  one-cycle strobe, high in the cycle leds shows a newly advanced pattern
- wrap  output  1  one-cycle strobe coincident with step when the pattern completes a cycle

## Operation
- Reset (nrst low, async): leds = 1 (LSB only), cnt = 0, dir = LEFT, phase = FILL, step = 0, wrap = 0.
- Priority per edge: load > tick > hold.
- load: leds <= seed, cnt <= 0, dir <= LEFT, phase <= FILL, step <= 0, wrap <= 0. The tick is suppressed that cycle.
- Prescaler: when en is high, tick = (cnt >= div). On tick cnt <= 0, else cnt <= cnt+1. When en is low, cnt holds and no tick occurs. Lowering div below cnt produces a tick on the next en cycle.
- mode is sampled on every tick. dir and phase are retained across mode changes. The pattern continues from the current leds.
- Rotate-left: leds <= {leds[W-2:0], leds[W-1]}. wrap = old leds[W-1].
- Rotate-right: leds <= {leds[0], leds[W-1:1]}. wrap = old leds[0].
- Ping-pong: logical shifts, zero filled, using the dir state.
  - dir LEFT and old leds[W-1]=1: dir <= RIGHT, shift right, wrap = 1.
  - dir RIGHT and old leds[0]=1: dir <= LEFT, shift left, wrap = 1.
  - Otherwise: shift in dir, wrap = 0.
- Fill/drain: phase state machine.
  - FILL with leds all ones: phase <= DRAIN, leds <= {leds[W-2:0],0}, wrap = 1.
  - FILL otherwise: leds <= {leds[W-2:0],1}.
  - DRAIN with leds all zeros: phase <= FILL, leds <= {leds[W-2:0],1}, wrap = 1.
  - DRAIN otherwise: leds <= {leds[W-2:0],0}.
- step <= tick and no load. wrap <= step condition and wrap rule, otherwise 0.
- An all-zero pattern in the rotate or ping-pong modes stays zero and never wraps. step still pulses.

## Timing
- load to leds = seed: 1 clock.
- Tick period = div+1 en-high cycles. The first tick after reset or load arrives div+1 en cycles later.
- leds, step and wrap are registered and change on the same edge. There is no combinational input-to-output path.
- Ping-pong period for a single-bit pattern: 2·(W-1) ticks.
- Fill/drain period: 2·W ticks.
- Rotate period: W ticks.
- nrst asserted mid-operation clears immediately, without waiting for clk. Deassertion is taken at the next edge.

## Test plan
- Reset, WIDTH=8, mode=00, div=0, en=1 → leds 01,02,04,…,80,01. wrap on the 80→01 step. step is high every cycle.
- WIDTH=4, mode=10, div=0, from reset → leds 2,4,8,4,2,1,2. wrap on the 8→4 and 1→2 steps.
- WIDTH=4, mode=11, load seed=0 → leds 1,3,7,F,E,C,8,0,1. wrap on F→E and 0→1.
- div=3, mode=01, en=1 → step every 4th cycle. Dropping en for 5 cycles mid-count delays the next step by exactly 5. With en low, leds are unchanged.
- load asserted in a tick cycle, seed=A5 → leds=A5 next edge, no step. The next step arrives div+1 cycles later.
- nrst pulsed low between clock edges during ping-pong with dir RIGHT → leds=01 immediately, step=wrap=0. The first post-reset step moves left (01→02).

Source files
------------

// File: rtl/light_dance_engine.sv
// ---------------------------------------------------------------------------
// light_dance_engine
//   Registered LED pattern generator. A programmable prescaler produces a
//   tick every div+1 enabled cycles; on each tick the WIDTH-bit pattern
//   advances in one of four modes (rotate-left, rotate-right, ping-pong,
//   fill/drain). step/wrap strobes accompany each newly shown pattern.
//
// Ports:
//   clk   in   system clock, rising-edge active
//   nrst  in   asynchronous active-low reset
//   en    in   prescaler enable; low freezes counter and pattern
//   mode  in   2'b00 rotl, 2'b01 rotr, 2'b10 ping-pong, 2'b11 fill/drain
//   load  in   synchronous seed load, overrides any tick in the same cycle
//   seed  in   pattern loaded on load
//   div   in   tick period minus one
//   leds  out  registered pattern
//   step  out  one-cycle strobe: leds shows a freshly advanced pattern
//   wrap  out  one-cycle strobe with step when the pattern closes a cycle
// ---------------------------------------------------------------------------
module light_dance_engine #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] leds,
  output logic             step,
  output logic             wrap
);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic {
    PH_FILL  = 1'b0,
    PH_DRAIN = 1'b1
  } phase_e;

  localparam logic [WIDTH-1:0] LEDS_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LEDS_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] LEDS_RESET = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] CNT_ZERO   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};

  // Pattern shift helpers; in_bit is what enters the vacated position.
  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v, input logic in_bit);
    shl = {v[WIDTH-2:0], in_bit};
  endfunction

  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v, input logic in_bit);
    shr = {in_bit, v[WIDTH-1:1]};
  endfunction

  logic [WIDTH-1:0] r_leds;
  logic [DIV_W-1:0] r_cnt;
  dir_e             r_dir;
  phase_e           r_phase;
  logic             r_step;
  logic             r_wrap;

  logic             w_tick;
  logic [WIDTH-1:0] w_adv_leds;
  dir_e             w_adv_dir;
  phase_e           w_adv_phase;
  logic             w_adv_wrap;

  // Prescaler tick: a load in the same cycle suppresses it. Using >= means a
  // div lowered below the running count ticks on the next enabled cycle.
  always_comb begin
    w_tick = en & ~load & (r_cnt >= div);
  end

  // Advanced pattern for the current mode, applied only when a tick occurs.
  always_comb begin
    w_adv_leds  = r_leds;
    w_adv_dir   = r_dir;
    w_adv_phase = r_phase;
    w_adv_wrap  = 1'b0;
    case (mode)
      2'b00: begin
        w_adv_leds = shl(r_leds, r_leds[WIDTH-1]);
        w_adv_wrap = r_leds[WIDTH-1];
      end
      2'b01: begin
        w_adv_leds = shr(r_leds, r_leds[0]);
        w_adv_wrap = r_leds[0];
      end
      2'b10: begin
        // Bounce happens the tick after the lit bit reaches an end.
        if ((r_dir == DIR_LEFT) && r_leds[WIDTH-1]) begin
          w_adv_dir  = DIR_RIGHT;
          w_adv_leds = shr(r_leds, 1'b0);
          w_adv_wrap = 1'b1;
        end else if ((r_dir == DIR_RIGHT) && r_leds[0]) begin
          w_adv_dir  = DIR_LEFT;
          w_adv_leds = shl(r_leds, 1'b0);
          w_adv_wrap = 1'b1;
        end else if (r_dir == DIR_LEFT) begin
          w_adv_leds = shl(r_leds, 1'b0);
        end else begin
          w_adv_leds = shr(r_leds, 1'b0);
        end
      end
      2'b11: begin
        if (r_phase == PH_FILL) begin
          if (r_leds == LEDS_ONES) begin
            w_adv_phase = PH_DRAIN;
            w_adv_leds  = shl(r_leds, 1'b0);
            w_adv_wrap  = 1'b1;
          end else begin
            w_adv_leds  = shl(r_leds, 1'b1);
          end
        end else begin
          if (r_leds == LEDS_ZERO) begin
            w_adv_phase = PH_FILL;
            w_adv_leds  = shl(r_leds, 1'b1);
            w_adv_wrap  = 1'b1;
          end else begin
            w_adv_leds  = shl(r_leds, 1'b0);
          end
        end
      end
      default: begin
        w_adv_leds  = r_leds;
        w_adv_dir   = r_dir;
        w_adv_phase = r_phase;
        w_adv_wrap  = 1'b0;
      end
    endcase
  end

  // State register: reset, then load > tick > hold/count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_leds  <= LEDS_RESET;
      r_cnt   <= CNT_ZERO;
      r_dir   <= DIR_LEFT;
      r_phase <= PH_FILL;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_leds  <= seed;
      r_cnt   <= CNT_ZERO;
      r_dir   <= DIR_LEFT;
      r_phase <= PH_FILL;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_tick) begin
      r_leds  <= w_adv_leds;
      r_cnt   <= CNT_ZERO;
      r_dir   <= w_adv_dir;
      r_phase <= w_adv_phase;
      r_step  <= 1'b1;
      r_wrap  <= w_adv_wrap;
    end else begin
      if (en) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign leds = r_leds;
  assign step = r_step;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_light_dance_engine.sv
module tb_light_dance_engine;

  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk;
  logic          nrst;
  logic          en;
  logic [1:0]    mode;
  logic          load;
  logic [W-1:0]  seed;
  logic [DW-1:0] div;
  logic [W-1:0]  leds;
  logic          step;
  logic          wrap;

  int n_vec;
  int n_err;

  // Reference model state
  int m_leds;
  int m_cnt;
  bit m_left;
  bit m_fill;
  bit m_step;
  bit m_wrap;

  light_dance_engine #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk (clk),
    .nrst(nrst),
    .en  (en),
    .mode(mode),
    .load(load),
    .seed(seed),
    .div (div),
    .leds(leds),
    .step(step),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_leds = 1;
    m_cnt  = 0;
    m_left = 1'b1;
    m_fill = 1'b1;
    m_step = 1'b0;
    m_wrap = 1'b0;
  endtask

  // Behavioural rules applied with integer arithmetic on the pattern.
  task automatic model_edge();
    int full;
    full = (1 << W) - 1;
    if (load) begin
      m_leds = int'(seed);
      m_cnt  = 0;
      m_left = 1'b1;
      m_fill = 1'b1;
      m_step = 1'b0;
      m_wrap = 1'b0;
    end else if (en && (m_cnt >= int'(div))) begin
      m_cnt  = 0;
      m_step = 1'b1;
      m_wrap = 1'b0;
      case (mode)
        2'd0: begin
          m_wrap = (m_leds >= (1 << (W-1)));
          m_leds = ((m_leds * 2) % (1 << W)) + (m_wrap ? 1 : 0);
        end
        2'd1: begin
          m_wrap = (m_leds % 2 == 1);
          m_leds = (m_leds / 2) + (m_wrap ? (1 << (W-1)) : 0);
        end
        2'd2: begin
          if (m_left && m_leds >= (1 << (W-1))) begin
            m_left = 1'b0; m_wrap = 1'b1; m_leds = m_leds / 2;
          end else if (!m_left && (m_leds % 2 == 1)) begin
            m_left = 1'b1; m_wrap = 1'b1; m_leds = (m_leds * 2) % (1 << W);
          end else if (m_left) begin
            m_leds = (m_leds * 2) % (1 << W);
          end else begin
            m_leds = m_leds / 2;
          end
        end
        default: begin
          if (m_fill && m_leds == full) begin
            m_fill = 1'b0; m_wrap = 1'b1; m_leds = (m_leds * 2) % (1 << W);
          end else if (m_fill) begin
            m_leds = (m_leds * 2 + 1) % (1 << W);
          end else if (m_leds == 0) begin
            m_fill = 1'b1; m_wrap = 1'b1; m_leds = 1;
          end else begin
            m_leds = (m_leds * 2) % (1 << W);
          end
        end
      endcase
    end else begin
      if (en) m_cnt = m_cnt + 1;
      m_step = 1'b0;
      m_wrap = 1'b0;
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_leds"}, int'(leds), m_leds);
    chk({tag, "_step"}, int'(step), int'(m_step));
    chk({tag, "_wrap"}, int'(wrap), int'(m_wrap));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nrst = 1'b0; en = 1'b0; mode = 2'd0; load = 1'b0;
    seed = '0; div = '0;
    model_reset();
    #12;
    chk("reset_leds", int'(leds), 1);
    chk("reset_step", int'(step), 0);
    chk("reset_wrap", int'(wrap), 0);
    nrst = 1'b1;
    @(posedge clk); #1;  // en low: nothing moves
    chk("idle_leds", int'(leds), 1);

    // Rotate-left, div=0: 02..80 then 01 with wrap on the 8th tick.
    en = 1'b1; mode = 2'd0; div = 16'd0;
    for (int i = 0; i < 8; i++) cyc("rotl");
    chk("rotl_wrap_leds", int'(leds), 1);
    chk("rotl_wrap_flag", int'(wrap), 1);
    for (int i = 0; i < 3; i++) cyc("rotl");

    // Ping-pong from the current single-bit pattern.
    mode = 2'd2;
    for (int i = 0; i < 20; i++) cyc("ping");

    // Fill/drain from an all-zero seed.
    load = 1'b1; seed = 8'h00; mode = 2'd3;
    cyc("fd_load");
    load = 1'b0;
    for (int i = 0; i < 18; i++) cyc("fill");

    // Rotate-right with div=3, then an en gap mid-count.
    mode = 2'd1; div = 16'd3;
    for (int i = 0; i < 10; i++) cyc("rotr_div");
    en = 1'b0;
    for (int i = 0; i < 5; i++) cyc("en_low");
    en = 1'b1;
    for (int i = 0; i < 10; i++) cyc("rotr_resume");

    // Load in a tick cycle: tick is suppressed.
    begin
      int guard;
      guard = 0;
      while (m_cnt < int'(div) && guard < 10) begin
        cyc("seek_tick");
        guard++;
      end
      chk("seek_tick_bound", int'(guard < 10), 1);
    end
    load = 1'b1; seed = 8'hA5;
    cyc("tick_load");
    chk("tick_load_leds", int'(leds), 8'hA5);
    chk("tick_load_step", int'(step), 0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) cyc("post_load");

    // Async reset during ping-pong with dir RIGHT.
    mode = 2'd2; div = 16'd0;
    load = 1'b1; seed = 8'h80;
    cyc("pp_load");
    load = 1'b0;
    cyc("pp_bounce");  // 80 -> 40, now moving right
    cyc("pp_right");   // 40 -> 20
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    chk("areset_leds", int'(leds), 1);
    chk("areset_step", int'(step), 0);
    chk("areset_wrap", int'(wrap), 0);
    #1;
    nrst = 1'b1;
    cyc("post_reset");
    chk("post_reset_left", int'(leds), 2);

    // Zero pattern in rotate/ping-pong modes never wraps.
    load = 1'b1; seed = 8'h00;
    cyc("zero_load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = 2'(i % 3);
      cyc("zero_pat");
    end

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 24) == 0);
      seed = W'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 30) == 0) div = DW'($urandom_range(0, 4));
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
